// File: rtl/prbs_pkg.sv
// Shared PRBS-15 definitions, used by both the generator stage and the checker.
//   LFSR_W / BYTE_W : sequence register width and bits consumed per byte
//   TAP_A / TAP_B   : history positions XORed to predict the next bit
//                     (position 0 holds the newest bit, so 14 is b[n-15] and 13 is b[n-14])
//   FILL_BYTES      : bytes needed to fill the 15-bit history before bits can be predicted
//   prbs_state_t    : checker synchronisation state
//   popcount8       : number of set bits in a byte
package prbs_pkg;

    localparam int LFSR_W = 15;
    localparam int BYTE_W = 8;
    localparam int TAP_A  = 14;
    localparam int TAP_B  = 13;

    localparam logic [1:0] FILL_BYTES = 2'd2;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs15_next8.sv
// Advances a PRBS-15 state by one byte (8 serial steps), feeding each step
// with its own predicted bit.
//   state      in  15  current sequence state, bit 0 = most recent bit
//   state_next out 15  state after 8 steps
//   pred       out 8   predicted bits, bit 7 is the first in time
module prbs15_next8
    import prbs_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_next,
    output logic [BYTE_W-1:0] pred
);

    always_comb begin
        state_next = state;
        pred       = '0;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            pred[i]    = state_next[TAP_A] ^ state_next[TAP_B];
            state_next = {state_next[LFSR_W-2:0], pred[i]};
        end
    end

endmodule

// File: rtl/prbs15_checker.sv
// PRBS-15 (x^15 + x^14 + 1) byte-stream checker with lock acquisition,
// loss-of-lock detection and a saturating bit-error counter.
//   clk          in  1      clock
//   rst_n        in  1      asynchronous active-low reset
//   data_in      in  8      received byte, bit 7 earliest
//   data_valid   in  1      data_in is consumed this edge
//   clear_cnt    in  1      synchronous clear of bit_err_cnt / err_sat
//   locked       out 1      synchronised to the stream
//   byte_err     out 1      pulse: last consumed byte had errors while locked
//   bit_err_cnt  out ERR_W  saturating errored-bit count (locked only)
//   err_sat      out 1      sticky: bit_err_cnt reached all-ones
//
// state  | meaning
// SEARCH | shifting received bits into history, counting clean bytes toward lock
// LOCKED | history free-runs as a local LFSR, received bytes compared against it
module prbs15_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 4,
    parameter int ERR_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              byte_err,
    output logic [ERR_W-1:0]  bit_err_cnt,
    output logic              err_sat
);

    localparam int CLEAN_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W   = $clog2(UNLOCK_COUNT + 1);
    localparam int SUM_W   = ERR_W + 4;
    localparam logic [SUM_W-1:0] CNT_MAX = {4'b0000, {ERR_W{1'b1}}};

    prbs_state_t          state_q, state_d;
    logic [LFSR_W-1:0]    hist_q, hist_d;
    logic [1:0]           fill_q, fill_d;
    logic [CLEAN_W-1:0]   clean_q, clean_d;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic                 byte_err_d;
    logic [3:0]           err_add;

    // Feed-forward view: each received bit is predicted from the 15 bits
    // before it, which may themselves be earlier bits of the same byte.
    logic [LFSR_W+BYTE_W-1:0] window;
    logic [BYTE_W-1:0]        ff_pred;
    logic [LFSR_W-1:0]        ff_hist;
    logic [BYTE_W-1:0]        ff_mismatch;

    assign window      = {hist_q, data_in};
    assign ff_hist     = {hist_q[LFSR_W-BYTE_W-1:0], data_in};
    assign ff_mismatch = data_in ^ ff_pred;

    always_comb begin
        ff_pred = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            ff_pred[i] = window[i+TAP_A+1] ^ window[i+TAP_B+1];
        end
    end

    // Locked view: the history register runs as a free LFSR.
    logic [LFSR_W-1:0] lfsr_next;
    logic [BYTE_W-1:0] lfsr_pred;
    logic [3:0]        lk_errs;

    prbs15_next8 u_next8 (
        .state      (hist_q),
        .state_next (lfsr_next),
        .pred       (lfsr_pred)
    );

    assign lk_errs = popcount8(data_in ^ lfsr_pred);

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        clean_d    = clean_q;
        bad_d      = bad_q;
        byte_err_d = 1'b0;
        err_add    = 4'd0;
        if (data_valid) begin
            case (state_q)
                SEARCH: begin
                    hist_d = ff_hist;
                    if (fill_q != FILL_BYTES) begin
                        fill_d = fill_q + 2'd1;
                    end else if (ff_mismatch == '0 && ff_hist != '0) begin
                        if (int'(clean_q) == LOCK_COUNT - 1) begin
                            state_d = LOCKED;
                            clean_d = '0;
                        end else begin
                            clean_d = clean_q + 1'b1;
                        end
                    end else begin
                        clean_d = '0;
                    end
                end
                LOCKED: begin
                    hist_d = lfsr_next;
                    if (lk_errs != 4'd0) begin
                        byte_err_d = 1'b1;
                        err_add    = lk_errs;
                        if (int'(bad_q) == UNLOCK_COUNT - 1) begin
                            state_d = SEARCH;
                            hist_d  = '0;
                            fill_d  = 2'd0;
                            clean_d = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            hist_q   <= '0;
            fill_q   <= 2'd0;
            clean_q  <= '0;
            bad_q    <= '0;
            byte_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            clean_q  <= clean_d;
            bad_q    <= bad_d;
            byte_err <= byte_err_d;
        end
    end

    logic [SUM_W-1:0] err_sum;
    assign err_sum = {4'b0000, bit_err_cnt} + {{(SUM_W-4){1'b0}}, err_add};

    // A clear on the same edge as an errored byte discards that byte's errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_err_cnt <= '0;
            err_sat     <= 1'b0;
        end else if (clear_cnt) begin
            bit_err_cnt <= '0;
            err_sat     <= 1'b0;
        end else if (err_add != 4'd0) begin
            if (err_sum >= CNT_MAX) begin
                bit_err_cnt <= '1;
                err_sat     <= 1'b1;
            end else begin
                bit_err_cnt <= err_sum[ERR_W-1:0];
            end
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs15_checker.sv
// Directed testbench for prbs15_checker: a default-width instance and an
// ERR_W=4 instance share one stimulus stream.
module tb_prbs15_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        clear_cnt = 1'b0;

    logic        locked, byte_err, err_sat;
    logic [15:0] bit_err_cnt;
    logic        locked4, byte_err4, err_sat4;
    logic [3:0]  bit_err_cnt4;

    logic [14:0] gen;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    prbs15_checker dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .clear_cnt(clear_cnt), .locked(locked), .byte_err(byte_err),
        .bit_err_cnt(bit_err_cnt), .err_sat(err_sat)
    );

    prbs15_checker #(.ERR_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .clear_cnt(clear_cnt), .locked(locked4), .byte_err(byte_err4),
        .bit_err_cnt(bit_err_cnt4), .err_sat(err_sat4)
    );

    // Reference generator: serial x^15+x^14+1, bit 7 of each byte first.
    task automatic next_prbs(output logic [7:0] b);
        logic nb;
        for (int i = 7; i >= 0; i--) begin
            nb   = gen[14] ^ gen[13];
            gen  = {gen[13:0], nb};
            b[i] = nb;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; data_valid = 1'b0; clear_cnt = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gen = 15'h7FFF;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic clr);
        @(negedge clk);
        data_in = b; data_valid = 1'b1; clear_cnt = clr;
        @(posedge clk);
        #1;
        data_valid = 1'b0; clear_cnt = 1'b0;
    endtask

    task automatic send_good(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            next_prbs(b);
            send_byte(b, 1'b0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", locked); else n_pass++;
        n_total++; if (byte_err !== 1'b0) $display("FAIL reset_byte_err: got %0b want 0", byte_err); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", bit_err_cnt); else n_pass++;
        n_total++; if (err_sat !== 1'b0) $display("FAIL reset_sat: got %0b want 0", err_sat); else n_pass++;
    endtask

    task automatic test_lock();
        logic [7:0] b;
        logic early_lock, any_err;
        early_lock = 1'b0; any_err = 1'b0;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            next_prbs(b);
            send_byte(b, 1'b0);
            if (k < 6 && locked) early_lock = 1'b1;
            if (byte_err) any_err = 1'b1;
        end
        n_total++; if (early_lock !== 1'b0) $display("FAIL lock_early: locked before byte 6 got %0b want 0", early_lock); else n_pass++;
        n_total++; if (locked !== 1'b1) $display("FAIL lock_after_6: got %0b want 1", locked); else n_pass++;
        n_total++; if (any_err !== 1'b0) $display("FAIL lock_byte_err: pulse seen %0b want 0", any_err); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd0) $display("FAIL lock_cnt: got %0d want 0", bit_err_cnt); else n_pass++;
    endtask

    task automatic test_single_error();
        logic [7:0] b;
        send_good(1);
        n_total++; if (byte_err !== 1'b0) $display("FAIL single_pre: byte_err got %0b want 0", byte_err); else n_pass++;
        next_prbs(b);
        send_byte(b ^ 8'h08, 1'b0);
        n_total++; if (byte_err !== 1'b1) $display("FAIL single_pulse: byte_err got %0b want 1", byte_err); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd1) $display("FAIL single_cnt: got %0d want 1", bit_err_cnt); else n_pass++;
        n_total++; if (bit_err_cnt4 !== 4'd1) $display("FAIL single_cnt_w4: got %0d want 1", bit_err_cnt4); else n_pass++;
        n_total++; if (locked !== 1'b1) $display("FAIL single_locked: got %0b want 1", locked); else n_pass++;
        send_good(1);
        n_total++; if (byte_err !== 1'b0) $display("FAIL single_pulse_end: byte_err got %0b want 0", byte_err); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd1) $display("FAIL single_cnt_hold: got %0d want 1", bit_err_cnt); else n_pass++;
    endtask

    task automatic test_unlock_relock();
        logic [7:0] b;
        do_reset();
        send_good(6);
        for (int k = 1; k <= 4; k++) begin
            next_prbs(b);
            send_byte(~b, 1'b0);
            if (k == 3) begin
                n_total++; if (locked !== 1'b1) $display("FAIL unlock_after_3: locked got %0b want 1", locked); else n_pass++;
            end
        end
        n_total++; if (locked !== 1'b0) $display("FAIL unlock_after_4: locked got %0b want 0", locked); else n_pass++;
        n_total++; if (byte_err !== 1'b1) $display("FAIL unlock_last_err: byte_err got %0b want 1", byte_err); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd32) $display("FAIL unlock_cnt: got %0d want 32", bit_err_cnt); else n_pass++;
        send_good(5);
        n_total++; if (locked !== 1'b0) $display("FAIL relock_after_5: locked got %0b want 0", locked); else n_pass++;
        send_good(1);
        n_total++; if (locked !== 1'b1) $display("FAIL relock_after_6: locked got %0b want 1", locked); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd32) $display("FAIL relock_cnt: got %0d want 32", bit_err_cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [7:0] b;
        do_reset();
        send_good(6);
        next_prbs(b); send_byte(~b, 1'b0);
        n_total++; if (bit_err_cnt4 !== 4'd8 || err_sat4 !== 1'b0) $display("FAIL sat_first: cnt %0d sat %0b want 8 0", bit_err_cnt4, err_sat4); else n_pass++;
        next_prbs(b); send_byte(~b, 1'b0);
        n_total++; if (bit_err_cnt4 !== 4'd15) $display("FAIL sat_cnt: got %0d want 15", bit_err_cnt4); else n_pass++;
        n_total++; if (err_sat4 !== 1'b1) $display("FAIL sat_flag: got %0b want 1", err_sat4); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd16 || err_sat !== 1'b0) $display("FAIL sat_wide: cnt %0d sat %0b want 16 0", bit_err_cnt, err_sat); else n_pass++;
        send_good(1);
        n_total++; if (err_sat4 !== 1'b1 || bit_err_cnt4 !== 4'd15) $display("FAIL sat_sticky: cnt %0d sat %0b want 15 1", bit_err_cnt4, err_sat4); else n_pass++;
        @(negedge clk); clear_cnt = 1'b1;
        @(posedge clk); #1; clear_cnt = 1'b0;
        n_total++; if (bit_err_cnt4 !== 4'd0 || err_sat4 !== 1'b0) $display("FAIL sat_clear: cnt %0d sat %0b want 0 0", bit_err_cnt4, err_sat4); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd0) $display("FAIL sat_clear_wide: got %0d want 0", bit_err_cnt); else n_pass++;
        next_prbs(b); send_byte(~b, 1'b0);
        next_prbs(b); send_byte(~b, 1'b0);
        next_prbs(b); send_byte(~b, 1'b1);
        n_total++; if (bit_err_cnt4 !== 4'd0 || err_sat4 !== 1'b0) $display("FAIL clear_wins: cnt %0d sat %0b want 0 0", bit_err_cnt4, err_sat4); else n_pass++;
        n_total++; if (byte_err4 !== 1'b1 || locked4 !== 1'b1) $display("FAIL clear_pulse: byte_err %0b locked %0b want 1 1", byte_err4, locked4); else n_pass++;
    endtask

    task automatic test_zero_stream();
        logic any_lock;
        any_lock = 1'b0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            send_byte(8'h00, 1'b0);
            if (locked) any_lock = 1'b1;
        end
        n_total++; if (any_lock !== 1'b0) $display("FAIL zero_stream: locked seen %0b want 0", any_lock); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd0) $display("FAIL zero_cnt: got %0d want 0", bit_err_cnt); else n_pass++;
    endtask

    task automatic test_gaps();
        logic [7:0] b;
        logic early_lock, any_err;
        int gap;
        early_lock = 1'b0; any_err = 1'b0;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            next_prbs(b);
            send_byte(b, 1'b0);
            if (k < 6 && locked) early_lock = 1'b1;
            if (byte_err) any_err = 1'b1;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); data_in = 8'($urandom);
                if (byte_err) any_err = 1'b1;
                if (k < 6 && locked) early_lock = 1'b1;
            end
        end
        n_total++; if (early_lock !== 1'b0) $display("FAIL gaps_early: got %0b want 0", early_lock); else n_pass++;
        n_total++; if (locked !== 1'b1) $display("FAIL gaps_lock: got %0b want 1", locked); else n_pass++;
        n_total++; if (any_err !== 1'b0 || bit_err_cnt !== 16'd0) $display("FAIL gaps_err: pulse %0b cnt %0d want 0 0", any_err, bit_err_cnt); else n_pass++;
        repeat (3) begin @(negedge clk); data_in = 8'($urandom); end
        #1;
        n_total++; if (locked !== 1'b1 || byte_err !== 1'b0) $display("FAIL gaps_hold: locked %0b byte_err %0b want 1 0", locked, byte_err); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        do_reset();
        send_good(6);
        next_prbs(b);
        send_byte(b ^ 8'h01, 1'b0);
        n_total++; if (byte_err !== 1'b1 || bit_err_cnt !== 16'd1) $display("FAIL areset_pre: byte_err %0b cnt %0d want 1 1", byte_err, bit_err_cnt); else n_pass++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (locked !== 1'b0 || byte_err !== 1'b0) $display("FAIL areset_now: locked %0b byte_err %0b want 0 0", locked, byte_err); else n_pass++;
        n_total++; if (bit_err_cnt !== 16'd0 || err_sat !== 1'b0) $display("FAIL areset_cnt: cnt %0d sat %0b want 0 0", bit_err_cnt, err_sat); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gen = 15'h7FFF;
        send_good(5);
        n_total++; if (locked !== 1'b0) $display("FAIL areset_relock_5: got %0b want 0", locked); else n_pass++;
        send_good(1);
        n_total++; if (locked !== 1'b1) $display("FAIL areset_relock_6: got %0b want 1", locked); else n_pass++;
    endtask

    initial begin
        gen = 15'h7FFF;
        test_reset();
        test_lock();
        test_single_error();
        test_unlock_relock();
        test_saturation();
        test_zero_stream();
        test_gaps();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prbs15_checker.md
PRBS15_CHECKER -- requirements
Module: prbs15_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive clean bytes in SEARCH needed to lock.
REQ-002 Parameter UNLOCK_COUNT, default 4: consecutive errored bytes in LOCKED needed to drop lock.
REQ-003 Parameter ERR_W, default 16: width of the bit-error counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 data_in  in  8  PRBS-15 byte stream from the generator stage; bit 7 is the earliest bit in time.
REQ-007 data_valid  in  1  data_in is consumed on a rising edge only when this is high.
REQ-008 clear_cnt  in  1  synchronous clear of bit_err_cnt and err_sat.
REQ-009 locked  out  1  checker is synchronised to the stream.
REQ-010 byte_err  out  1  one-cycle pulse: the last consumed byte had at least 1 bit error while LOCKED.
REQ-011 bit_err_cnt  out  ERR_W  saturating count of errored bits seen while LOCKED.
REQ-012 err_sat  out  1  sticky flag: bit_err_cnt reached all-ones.

Function
REQ-013 Polynomial x^15+x^14+1; each sequence bit b[n] SHALL equal b[n-15] XOR b[n-14]; each byte is processed as 8 serial steps, bit 7 first.
REQ-014 FSM states SHALL be SEARCH and LOCKED; reset state SEARCH.
REQ-015 SEARCH: received bits SHALL be shifted into a 15-bit history (feed-forward), and each bit compared with the prediction from the history.
REQ-016 SEARCH: the first 2 bytes after entry fill the history and SHALL NOT be evaluated.
REQ-017 SEARCH: a byte counts as clean only if all 8 predictions match AND the resulting history is non-zero; an all-zero stream SHALL never lock.
REQ-018 SEARCH: a non-clean byte SHALL reset the clean-byte counter to 0; at LOCK_COUNT clean bytes the FSM SHALL enter LOCKED, with the history as the LFSR seed.
REQ-019 LOCKED: the LFSR SHALL free-run on its own predicted bits, never on received bits; the byte error count is popcount(received XOR predicted).
REQ-020 LOCKED: a byte with non-zero error count increments the bad-byte counter; a clean byte SHALL reset it to 0; at UNLOCK_COUNT the FSM SHALL return to SEARCH with the history and counters cleared.
REQ-021 Errors SHALL be counted only in LOCKED, including the byte that causes the unlock; SEARCH bytes never change bit_err_cnt.
REQ-022 Latency: locked, byte_err and bit_err_cnt SHALL reflect a consumed byte on the same rising edge that consumes it (registered, visible the following cycle).
REQ-023 data_valid low: all state SHALL hold and byte_err SHALL be 0.
REQ-024 bit_err_cnt SHALL saturate at 2^ERR_W-1 without wrapping; err_sat SHALL set on the same edge and stay high until clear_cnt.
REQ-025 clear_cnt coincident with an errored byte: clear SHALL win, giving bit_err_cnt=0 and err_sat=0; byte_err still pulses and the FSM still advances.

Reset
REQ-026 Asserting rst_n low SHALL immediately force locked=0, byte_err=0, bit_err_cnt=0, err_sat=0, state SEARCH, and history/LFSR, clean counter and bad counter to 0, regardless of clk.
REQ-027 Reset asserted mid-lock SHALL require full reacquisition (2 fill bytes + LOCK_COUNT clean bytes).
REQ-028 Release of rst_n SHALL be safe for the first data_valid on the next rising edge.

Structure
REQ-029 Shared package prbs_pkg SHALL hold the tap positions (14, 13), the LFSR width 15, the byte width 8 and the state enum {SEARCH, LOCKED}; the generator stage uses the same package.
REQ-030 One combinational sub-module prbs15_next8 SHALL compute the 8-step advanced state and the 8 predicted bits from a 15-bit state.

Verification
REQ-031 Reset, then 6 correct PRBS bytes from seed 0x7FFF -> locked rises after byte 6, bit_err_cnt=0, no byte_err.
REQ-032 Locked, flip bit 3 of one byte -> one byte_err pulse, bit_err_cnt=1, locked stays 1.
REQ-033 Locked, 4 consecutive inverted bytes -> bit_err_cnt=32, locked falls after byte 4; 6 good bytes relock.
REQ-034 ERR_W=4, locked, 2 inverted bytes -> bit_err_cnt=15, err_sat=1; clear_cnt pulse -> both 0.
REQ-035 Stream of 0x00 bytes for 20 bytes -> locked stays 0; random data_valid gaps on REQ-031 stimulus -> identical results.
REQ-036 rst_n low mid-lock between clock edges -> all outputs 0 at once; relock after exactly 6 bytes.
